// File: rtl/border_pkg.sv
// border_pkg: shared window geometry and FSM state codes for the window loader
package border_pkg;
   localparam int K         = 5;
   localparam int WIN_BYTES = K * K;
   localparam int DEF_PIX_W = 8;
   localparam int WIN_W     = WIN_BYTES * DEF_PIX_W;
   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] FETCH = 2'd1;
   localparam logic [1:0] DRAIN = 2'd2;
   localparam logic [1:0] HOLD  = 2'd3;
endpackage

// File: rtl/tap_addr_gen.sv
// tap_addr_gen: walks the 5x5 taps row-major, producing frame-buffer address and pad flag
module tap_addr_gen
   import border_pkg::*;
#(
   parameter int IMG_W  = 320,
   parameter int IMG_H  = 240,
   parameter int ADDR_W = 17
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load,
   input  logic              step,
   input  logic [8:0]        cx,
   input  logic [7:0]        cy,
   output logic [4:0]        idx,
   output logic [ADDR_W-1:0] addr,
   output logic              pad,
   output logic              last
);
   localparam logic signed [9:0]      XLIM = 10'(IMG_W);
   localparam logic signed [8:0]      YLIM = 9'(IMG_H);
   localparam logic signed [ADDR_W:0] ROW  = (ADDR_W+1)'(IMG_W);
   logic [2:0]               col, row;
   logic [8:0]               cx_r;
   logic [7:0]               cy_r;
   logic signed [ADDR_W:0]   row_base, base0;
   logic signed [9:0]        x;
   logic signed [8:0]        y, ym2;
   // Row base may start negative (top border); padded taps never use the address.
   always_comb begin
      ym2   = $signed({1'b0, cy}) - 9'sd2;
      base0 = $signed({{(ADDR_W-8){ym2[8]}}, ym2}) * ROW;
      x     = $signed({1'b0, cx_r}) + $signed({7'd0, col}) - 10'sd2;
      y     = $signed({1'b0, cy_r}) + $signed({6'd0, row}) - 9'sd2;
      pad   = x[9] || x >= XLIM || y[8] || y >= YLIM;
      addr  = ADDR_W'(row_base + $signed({{(ADDR_W-9){x[9]}}, x}));
      last  = idx == 5'(WIN_BYTES - 1);
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         idx      <= '0;
         col      <= '0;
         row      <= '0;
         cx_r     <= '0;
         cy_r     <= '0;
         row_base <= '0;
      end else if (load) begin
         idx      <= '0;
         col      <= '0;
         row      <= '0;
         cx_r     <= cx;
         cy_r     <= cy;
         row_base <= base0;
      end else if (step) begin
         idx      <= idx + 5'd1;
         col      <= col == 3'(K-1) ? 3'd0 : col + 3'd1;
         row      <= col == 3'(K-1) ? row + 3'd1 : row;
         row_base <= col == 3'(K-1) ? row_base + ROW : row_base;
      end
endmodule

// File: rtl/window_loader.sv
// window_loader: fetches a padded 5x5 neighbourhood from the frame buffer and holds it until ack
module window_loader
   import border_pkg::*;
#(
   parameter int IMG_W  = 320,
   parameter int IMG_H  = 240,
   parameter int PIX_W  = 8,
   parameter int ADDR_W = 17
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       start,
   input  logic [8:0]                 center_x,
   input  logic [7:0]                 center_y,
   output logic                       mem_rd,
   output logic [ADDR_W-1:0]          mem_addr,
   input  logic [PIX_W-1:0]           mem_data,
   output logic [WIN_BYTES*PIX_W-1:0] window,
   output logic                       window_valid,
   input  logic                       ack,
   output logic                       busy
);
   logic [1:0]        state;
   logic [4:0]        idx, cap_idx;
   logic              pad, last, cap_pad, cap_valid;
   logic [ADDR_W-1:0] addr;
   tap_addr_gen #(.IMG_W(IMG_W), .IMG_H(IMG_H), .ADDR_W(ADDR_W)) u_tap (
      .clk  (clk),
      .rst_n(rst_n),
      .load (state == IDLE && start),
      .step (state == FETCH),
      .cx   (center_x),
      .cy   (center_y),
      .idx  (idx),
      .addr (addr),
      .pad  (pad),
      .last (last)
   );
   always_comb begin
      busy         = state != IDLE;
      window_valid = state == HOLD;
      mem_rd       = state == FETCH && !pad;
      mem_addr     = mem_rd ? addr : '0;
   end
   // Tap index and pad flag trail the read by one cycle to line up with mem_data.
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state     <= IDLE;
         window    <= '0;
         cap_valid <= 1'b0;
         cap_idx   <= '0;
         cap_pad   <= 1'b0;
      end else begin
         cap_valid <= state == FETCH;
         cap_idx   <= idx;
         cap_pad   <= pad;
         if (state == IDLE && start)
            window <= '0;
         else if (cap_valid)
            window[cap_idx*PIX_W +: PIX_W] <= cap_pad ? '0 : mem_data;
         state <= state == IDLE  ? (start ? FETCH : IDLE) :
                  state == FETCH ? (last ? DRAIN : FETCH) :
                  state == DRAIN ? HOLD :
                  (ack ? IDLE : HOLD);
      end
endmodule

// File: tb/tb_window_loader.sv
// tb_window_loader: scoreboard bench with a frame-buffer model and a coordinate-level window model
module tb_window_loader;
   logic         clk = 0, rst_n = 0, start = 0, ack = 0;
   logic [8:0]   center_x = 0;
   logic [7:0]   center_y = 0;
   logic         mem_rd, window_valid, busy;
   logic [16:0]  mem_addr;
   logic [7:0]   mem_data = 0;
   logic [199:0] window;
   int           checks = 0, errors = 0, cyc = 0, rd_cnt = 0;
   logic         prev_v = 0;
   typedef struct {logic [199:0] w; int reads; int cyc;} exp_t;
   exp_t sbq[$];

   window_loader dut (
      .clk(clk), .rst_n(rst_n), .start(start), .center_x(center_x), .center_y(center_y),
      .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_data(mem_data), .window(window),
      .window_valid(window_valid), .ack(ack), .busy(busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (mem_rd) mem_data <= mem_addr[7:0];
   end

   task automatic chk(string name, logic [199:0] act, logic [199:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%h exp=%h", name, act, exp);
      end
   endtask

   function automatic exp_t model(int cx, int cy, int c);
      exp_t e;
      e.w = '0;
      e.reads = 0;
      e.cyc = c;
      for (int k = 0; k < 25; k++) begin
         int x, y;
         x = cx + k % 5 - 2;
         y = cy + k / 5 - 2;
         if (x >= 0 && x < 320 && y >= 0 && y < 240) begin
            e.w[k*8 +: 8] = 8'((y * 320 + x) % 256);
            e.reads++;
         end
      end
      return e;
   endfunction

   always @(negedge clk) begin
      if (!rst_n) begin
         rd_cnt = 0;
         prev_v = 0;
      end else begin
         if (mem_rd) rd_cnt++;
         if (window_valid && !prev_v) begin
            if (sbq.size() == 0) chk("unexpected_valid", 200'(1), 200'(0));
            else begin
               exp_t e;
               e = sbq.pop_front();
               chk("window", window, e.w);
               chk("reads", 200'(rd_cnt), 200'(e.reads));
               chk("latency", 200'(cyc), 200'(e.cyc));
            end
            rd_cnt = 0;
         end
         prev_v = window_valid;
      end
   end

   task automatic issue(int cx, int cy, output logic [199:0] w);
      exp_t e;
      @(negedge clk);
      center_x = 9'(cx);
      center_y = 8'(cy);
      start = 1;
      e = model(cx, cy, cyc + 27);
      sbq.push_back(e);
      w = e.w;
      @(negedge clk);
      start = 0;
   endtask

   task automatic finish_win(logic [199:0] w, int hold, bit with_start);
      int n = 0;
      while (!window_valid && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (!window_valid) begin
         chk("timeout", 200'(0), 200'(1));
         sbq.delete();
         return;
      end
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         chk("hold_window", window, w);
         chk("hold_valid", 200'(window_valid), 200'(1));
      end
      ack = 1;
      if (with_start) begin
         start = 1;
         center_x = 9'd100;
         center_y = 8'd100;
      end
      @(negedge clk);
      ack = 0;
      start = 0;
      chk("ack_valid", 200'(window_valid), 200'(0));
      chk("ack_busy", 200'(busy), 200'(0));
      chk("ack_window", window, w);
      if (with_start) begin
         repeat (3) @(negedge clk);
         chk("ack_start_dropped", 200'(busy), 200'(0));
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog act=running exp=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [199:0] w;
      #12;
      chk("rst_window", window, 200'(0));
      chk("rst_valid", 200'(window_valid), 200'(0));
      chk("rst_mem_rd", 200'(mem_rd), 200'(0));
      chk("rst_mem_addr", 200'(mem_addr), 200'(0));
      chk("rst_busy", 200'(busy), 200'(0));
      @(negedge clk);
      rst_n = 1;
      issue(10, 10, w);   finish_win(w, 2, 0);
      issue(0, 0, w);     finish_win(w, 0, 0);
      issue(319, 239, w); finish_win(w, 1, 0);
      issue(160, 120, w); finish_win(w, 10, 1);
      issue(50, 60, w);
      repeat (4) @(negedge clk);
      center_x = 9'd200;
      center_y = 8'd100;
      start = 1;
      @(negedge clk);
      start = 0;
      finish_win(w, 0, 0);
      repeat (3) @(negedge clk);
      chk("no_queued_start", 200'(busy), 200'(0));
      issue(100, 50, w);
      repeat (12) @(negedge clk);
      rst_n = 0;
      #1;
      chk("abort_window", window, 200'(0));
      chk("abort_valid", 200'(window_valid), 200'(0));
      chk("abort_mem_rd", 200'(mem_rd), 200'(0));
      chk("abort_mem_addr", 200'(mem_addr), 200'(0));
      chk("abort_busy", 200'(busy), 200'(0));
      sbq.delete();
      repeat (2) @(negedge clk);
      rst_n = 1;
      issue(5, 5, w); finish_win(w, 0, 0);
      for (int i = 0; i < 24; i++) begin
         int cx, cy;
         cx = (i % 4 == 0) ? int'($urandom_range(3)) : (i % 4 == 1) ? 316 + int'($urandom_range(3)) : int'($urandom_range(319));
         cy = (i % 3 == 0) ? int'($urandom_range(3)) : (i % 3 == 1) ? 236 + int'($urandom_range(3)) : int'($urandom_range(239));
         issue(cx, cy, w);
         finish_win(w, int'($urandom_range(3)), bit'($urandom_range(1)));
      end
      repeat (2) @(negedge clk);
      chk("queue_empty", 200'(sbq.size()), 200'(0));
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
